sdram_aref_sched: RTL and testbench

Parametrised auto-refresh scheduler for the SDRAM controller. It generates refresh ticks every tREFI and accumulates them as refresh debt, up to the JEDEC postpone limit. Under an arbiter grant it issues precharge-all followed by a burst of AUTO REFRESH commands. It raises an urgent request when the debt nears the limit and, while urgent, drains the entire debt in one grant. It sits beside the init, read and write modules and feeds the command arbiter.

---
 rtl/sdram_aref_sched_if.sv | 57 +++++
 rtl/sdram_aref_sched.sv | 192 +++++++++++++++++++
 tb/tb_sdram_aref_sched.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sdram_aref_sched_if.sv
`default_nettype none
// sdram_aref_sched_if: arbiter-facing bundle of the auto-refresh scheduler.
// ar_stat_cnt is present only when SDRAM_AREF_STATS_EN is defined.
interface sdram_aref_sched_if #(
  parameter int ADDR_W   = 13,
  parameter int BANK_W   = 2,
  parameter int MAX_DEBT = 8
);
  localparam int DEBT_W = $clog2(MAX_DEBT + 1);

  logic              init_end;
  logic              ar_en;
  logic              ar_req;
  logic              ar_urgent;
  logic [3:0]        ar_cmd;
  logic [BANK_W-1:0] ar_bank;
  logic [ADDR_W-1:0] ar_addr;
  logic              ar_end;
  logic [DEBT_W-1:0] ar_debt;
  logic              ar_ovf;
`ifdef SDRAM_AREF_STATS_EN
  logic [15:0]       ar_stat_cnt;
`endif

  modport slave (
    input  init_end,
    input  ar_en,
`ifdef SDRAM_AREF_STATS_EN
    output ar_stat_cnt,
`endif
    output ar_req,
    output ar_urgent,
    output ar_cmd,
    output ar_bank,
    output ar_addr,
    output ar_end,
    output ar_debt,
    output ar_ovf
  );

  modport master (
    output init_end,
    output ar_en,
`ifdef SDRAM_AREF_STATS_EN
    input  ar_stat_cnt,
`endif
    input  ar_req,
    input  ar_urgent,
    input  ar_cmd,
    input  ar_bank,
    input  ar_addr,
    input  ar_end,
    input  ar_debt,
    input  ar_ovf
  );
endinterface
`default_nettype wire

// File: rtl/sdram_aref_sched.sv
`default_nettype none
// sdram_aref_sched: tREFI tick generator, refresh-debt tracker and PRE-all + AUTO REFRESH sequencer.
// Optional macro SDRAM_AREF_STATS_EN adds the saturating AR command counter ar_stat_cnt.
module sdram_aref_sched #(
  parameter int T_REFI_CYC = 780,
  parameter int T_RP_CYC   = 2,
  parameter int T_RFC_CYC  = 7,
  parameter int AR_BURST   = 2,
  parameter int MAX_DEBT   = 8,
  parameter int URGENT_TH  = 6,
  parameter int ADDR_W     = 13,
  parameter int BANK_W     = 2
) (
  input  logic               ar_clk,
  input  logic               ar_rst_n,
  sdram_aref_sched_if.slave  ar_if
);
  localparam int DEBT_W   = $clog2(MAX_DEBT + 1);
  localparam int TMR_W    = (T_REFI_CYC > 2) ? $clog2(T_REFI_CYC) : 1;
  localparam int WAIT_MAX = (T_RP_CYC > T_RFC_CYC) ? T_RP_CYC : T_RFC_CYC;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int BCNT_W   = $clog2(AR_BURST + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_TRP  = 3'd2;
  localparam logic [2:0] S_AR   = 3'd3;
  localparam logic [2:0] S_TRFC = 3'd4;
  localparam logic [2:0] S_END  = 3'd5;

  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_AR  = 4'b0001;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(T_REFI_CYC - 1);
  localparam logic [WAIT_W-1:0] TRP_LOAD  = WAIT_W'(T_RP_CYC - 1);
  localparam logic [WAIT_W-1:0] TRFC_LOAD = WAIT_W'(T_RFC_CYC - 1);
  localparam logic [DEBT_W-1:0] DEBT_MAX  = DEBT_W'(MAX_DEBT);
  localparam logic [DEBT_W-1:0] DEBT_URG  = DEBT_W'(URGENT_TH);
  localparam logic [BCNT_W-1:0] BURST_LIM = BCNT_W'(AR_BURST);

  logic [2:0]        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              urg_mode_q, urg_mode_d;
  logic              ovf_q, ovf_d;
  logic [3:0]        cmd_q, cmd_d;
  logic              tick;
  logic              ar_issue;
  logic              urgent;

  assign tick     = ar_if.init_end && (tmr_q == TMR_LAST);
  assign ar_issue = (state_q == S_AR);
  assign urgent   = (debt_q >= DEBT_URG);

  always_comb begin
    tmr_d = tmr_q;
    if (!ar_if.init_end || (tmr_q == TMR_LAST)) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + TMR_W'(1);
    end
  end

  // A tick and an AR in the same cycle cancel, so debt only saturates when no AR absorbs the tick.
  always_comb begin
    debt_d = debt_q;
    ovf_d  = ovf_q;
    if (!ar_if.init_end) begin
      debt_d = '0;
    end else if (tick && !ar_issue) begin
      if (debt_q == DEBT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        debt_d = debt_q + DEBT_W'(1);
      end
    end else if (!tick && ar_issue) begin
      debt_d = debt_q - DEBT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    bcnt_d     = bcnt_q;
    urg_mode_d = urg_mode_q;
    if (!ar_if.init_end) begin
      state_d    = S_IDLE;
      wait_d     = '0;
      bcnt_d     = '0;
      urg_mode_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ar_if.ar_en && (debt_q != '0)) begin
            state_d    = S_PRE;
            urg_mode_d = urgent;
          end
        end
        S_PRE: begin
          state_d = S_TRP;
          wait_d  = TRP_LOAD;
        end
        S_TRP: begin
          if (wait_q == '0) begin
            state_d = S_AR;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
        S_AR: begin
          state_d = S_TRFC;
          wait_d  = TRFC_LOAD;
          if (bcnt_q != BURST_LIM) begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
        S_TRFC: begin
          if (wait_q != '0) begin
            wait_d = wait_q - WAIT_W'(1);
          end else if ((debt_q != '0) && (urg_mode_q || (bcnt_q < BURST_LIM))) begin
            state_d = S_AR;
          end else begin
            state_d = S_END;
          end
        end
        S_END: begin
          state_d = S_IDLE;
          bcnt_d  = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The command register follows the next state so ar_cmd lines up with the state it names.
  always_comb begin
    case (state_d)
      S_PRE:   cmd_d = CMD_PRE;
      S_AR:    cmd_d = CMD_AR;
      default: cmd_d = CMD_NOP;
    endcase
  end

  always_ff @(posedge ar_clk or negedge ar_rst_n) begin
    if (!ar_rst_n) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      debt_q     <= '0;
      wait_q     <= '0;
      bcnt_q     <= '0;
      urg_mode_q <= 1'b0;
      ovf_q      <= 1'b0;
      cmd_q      <= CMD_NOP;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      debt_q     <= debt_d;
      wait_q     <= wait_d;
      bcnt_q     <= bcnt_d;
      urg_mode_q <= urg_mode_d;
      ovf_q      <= ovf_d;
      cmd_q      <= cmd_d;
    end
  end

`ifdef SDRAM_AREF_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge ar_clk or negedge ar_rst_n) begin
    if (!ar_rst_n) begin
      stat_q <= '0;
    end else if (ar_issue && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign ar_if.ar_stat_cnt = stat_q;
`endif

  assign ar_if.ar_req    = (debt_q != '0) && (state_q == S_IDLE);
  assign ar_if.ar_urgent = urgent;
  assign ar_if.ar_cmd    = cmd_q;
  assign ar_if.ar_bank   = '1;
  assign ar_if.ar_addr   = '1;
  assign ar_if.ar_end    = (state_q == S_END);
  assign ar_if.ar_debt   = debt_q;
  assign ar_if.ar_ovf    = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_sdram_aref_sched.sv
`default_nettype none
// tb_sdram_aref_sched: directed bench for the auto-refresh scheduler (tREFI=100, tRP=2, tRFC=7, burst 2).
module tb_sdram_aref_sched;
  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] AR  = 4'b0001;

  logic ar_clk = 1'b0;
  logic ar_rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always #5 ar_clk = ~ar_clk;

  sdram_aref_sched_if #(.ADDR_W(13), .BANK_W(2), .MAX_DEBT(8)) bus ();

  sdram_aref_sched #(
    .T_REFI_CYC(100), .T_RP_CYC(2), .T_RFC_CYC(7), .AR_BURST(2),
    .MAX_DEBT(8), .URGENT_TH(6), .ADDR_W(13), .BANK_W(2)
  ) dut (
    .ar_clk   (ar_clk),
    .ar_rst_n (ar_rst_n),
    .ar_if    (bus.slave)
  );

  // Sample and drive 1 time unit after each rising edge; cyc counts edges since init_end rose.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge ar_clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_until(input int t);
    if (t > cyc) step(t - cyc);
  endtask

  // Grant in IDLE and follow the sequence: PRE at k=1, ARs at k=4+8*i, END at end_k.
  task automatic run_seq(input int n_ar, input int end_k, input bit pulse, input string nm);
    int ar_cnt;
    bit got_end;
    ar_cnt  = 0;
    got_end = 1'b0;
    bus.ar_en = 1'b1;
    for (int k = 1; k <= 200 && !got_end; k++) begin
      step(1);
      if (pulse && k == 1) bus.ar_en = 1'b0;
      if (k == 1) begin
        n_chk++; if (bus.ar_cmd !== PRE) begin n_fail++; $display("FAIL %s_first_cmd: got %b expected %b", nm, bus.ar_cmd, PRE); end
        n_chk++; if (bus.ar_addr !== 13'h1FFF || bus.ar_bank !== 2'b11) begin n_fail++; $display("FAIL %s_pre_addr: got addr %h bank %b expected 1fff 11", nm, bus.ar_addr, bus.ar_bank); end
      end
      if (bus.ar_cmd === AR) begin
        n_chk++; if (k != 4 + 8 * ar_cnt) begin n_fail++; $display("FAIL %s_ar_pos: AR at k=%0d expected k=%0d", nm, k, 4 + 8 * ar_cnt); end
        ar_cnt++;
      end
      if (bus.ar_end === 1'b1) begin
        got_end = 1'b1;
        n_chk++; if (k != end_k) begin n_fail++; $display("FAIL %s_end_pos: ar_end at k=%0d expected k=%0d", nm, k, end_k); end
        n_chk++; if (bus.ar_cmd !== NOP) begin n_fail++; $display("FAIL %s_end_cmd: got %b expected %b", nm, bus.ar_cmd, NOP); end
      end
    end
    bus.ar_en = 1'b0;
    n_chk++; if (!got_end) begin n_fail++; $display("FAIL %s_timeout: ar_end seen 0 expected 1", nm); end
    n_chk++; if (ar_cnt != n_ar) begin n_fail++; $display("FAIL %s_ar_count: got %0d expected %0d", nm, ar_cnt, n_ar); end
  endtask

  task automatic test_reset();
    ar_rst_n = 1'b0;
    bus.init_end = 1'b0;
    bus.ar_en = 1'b0;
    step(3);
    n_chk++; if (bus.ar_cmd !== NOP) begin n_fail++; $display("FAIL rst_cmd: got %b expected %b", bus.ar_cmd, NOP); end
    n_chk++; if (bus.ar_addr !== 13'h1FFF) begin n_fail++; $display("FAIL rst_addr: got %h expected 1fff", bus.ar_addr); end
    n_chk++; if (bus.ar_bank !== 2'b11) begin n_fail++; $display("FAIL rst_bank: got %b expected 11", bus.ar_bank); end
    n_chk++; if ({bus.ar_req, bus.ar_urgent, bus.ar_end, bus.ar_ovf} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b expected 0000", {bus.ar_req, bus.ar_urgent, bus.ar_end, bus.ar_ovf}); end
    n_chk++; if (bus.ar_debt !== 4'd0) begin n_fail++; $display("FAIL rst_debt: got %0d expected 0", bus.ar_debt); end
`ifdef SDRAM_AREF_STATS_EN
    n_chk++; if (bus.ar_stat_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_stat: got %0d expected 0", bus.ar_stat_cnt); end
`endif
    ar_rst_n = 1'b1;
  endtask

  task automatic test_accumulate();
    bus.init_end = 1'b1;
    cyc = 0;
    wait_until(99);
    n_chk++; if (bus.ar_req !== 1'b0 || bus.ar_debt !== 4'd0) begin n_fail++; $display("FAIL acc_99: got req %b debt %0d expected 0 0", bus.ar_req, bus.ar_debt); end
    wait_until(100);
    n_chk++; if (bus.ar_req !== 1'b1 || bus.ar_debt !== 4'd1) begin n_fail++; $display("FAIL acc_100: got req %b debt %0d expected 1 1", bus.ar_req, bus.ar_debt); end
    wait_until(599);
    n_chk++; if (bus.ar_urgent !== 1'b0 || bus.ar_debt !== 4'd5) begin n_fail++; $display("FAIL acc_599: got urgent %b debt %0d expected 0 5", bus.ar_urgent, bus.ar_debt); end
    wait_until(600);
    n_chk++; if (bus.ar_urgent !== 1'b1 || bus.ar_debt !== 4'd6) begin n_fail++; $display("FAIL acc_600: got urgent %b debt %0d expected 1 6", bus.ar_urgent, bus.ar_debt); end
    wait_until(800);
    n_chk++; if (bus.ar_debt !== 4'd8 || bus.ar_ovf !== 1'b0) begin n_fail++; $display("FAIL acc_800: got debt %0d ovf %b expected 8 0", bus.ar_debt, bus.ar_ovf); end
    wait_until(899);
    n_chk++; if (bus.ar_ovf !== 1'b0) begin n_fail++; $display("FAIL acc_899_ovf: got %b expected 0", bus.ar_ovf); end
    wait_until(900);
    n_chk++; if (bus.ar_debt !== 4'd8 || bus.ar_ovf !== 1'b1) begin n_fail++; $display("FAIL acc_900: got debt %0d ovf %b expected 8 1", bus.ar_debt, bus.ar_ovf); end
  endtask

  task automatic test_init_clear();
    bus.init_end = 1'b0;
    step(1);
    n_chk++; if (bus.ar_debt !== 4'd0 || bus.ar_req !== 1'b0 || bus.ar_urgent !== 1'b0) begin n_fail++; $display("FAIL clr_debt: got debt %0d req %b urgent %b expected 0 0 0", bus.ar_debt, bus.ar_req, bus.ar_urgent); end
    n_chk++; if (bus.ar_ovf !== 1'b1) begin n_fail++; $display("FAIL clr_ovf_sticky: got %b expected 1", bus.ar_ovf); end
    bus.init_end = 1'b1;
    cyc = 0;
  endtask

  task automatic test_single();
    wait_until(100);
    n_chk++; if (bus.ar_debt !== 4'd1 || bus.ar_req !== 1'b1) begin n_fail++; $display("FAIL single_pre: got debt %0d req %b expected 1 1", bus.ar_debt, bus.ar_req); end
    run_seq(1, 12, 1'b1, "single");
    n_chk++; if (bus.ar_debt !== 4'd0 || bus.ar_req !== 1'b0) begin n_fail++; $display("FAIL single_post: got debt %0d req %b expected 0 0", bus.ar_debt, bus.ar_req); end
    step(1);
    n_chk++; if (bus.ar_req !== 1'b0 || bus.ar_end !== 1'b0) begin n_fail++; $display("FAIL single_idle: got req %b end %b expected 0 0", bus.ar_req, bus.ar_end); end
  endtask

  task automatic test_burst();
    wait_until(400);
    n_chk++; if (bus.ar_debt !== 4'd3 || bus.ar_urgent !== 1'b0) begin n_fail++; $display("FAIL burst_pre: got debt %0d urgent %b expected 3 0", bus.ar_debt, bus.ar_urgent); end
    run_seq(2, 20, 1'b0, "burst");
    n_chk++; if (bus.ar_debt !== 4'd1 || bus.ar_req !== 1'b0) begin n_fail++; $display("FAIL burst_end: got debt %0d req %b expected 1 0", bus.ar_debt, bus.ar_req); end
    step(1);
    n_chk++; if (bus.ar_req !== 1'b1) begin n_fail++; $display("FAIL burst_rereq: got %b expected 1", bus.ar_req); end
  endtask

  // Grant at 1079 puts the 3rd AR on edge 1100, the same edge as a tick.
  task automatic test_urgent();
    wait_until(1079);
    n_chk++; if (bus.ar_debt !== 4'd7 || bus.ar_urgent !== 1'b1) begin n_fail++; $display("FAIL urg_pre: got debt %0d urgent %b expected 7 1", bus.ar_debt, bus.ar_urgent); end
    run_seq(8, 68, 1'b0, "urgent");
    n_chk++; if (bus.ar_debt !== 4'd0 || bus.ar_urgent !== 1'b0) begin n_fail++; $display("FAIL urg_post: got debt %0d urgent %b expected 0 0", bus.ar_debt, bus.ar_urgent); end
  endtask

  task automatic test_init_drop();
    bit saw_bad;
    saw_bad = 1'b0;
    wait_until(1400);
    n_chk++; if (bus.ar_debt !== 4'd3) begin n_fail++; $display("FAIL drop_pre: got debt %0d expected 3", bus.ar_debt); end
    bus.ar_en = 1'b1;
    step(1);
    n_chk++; if (bus.ar_cmd !== PRE) begin n_fail++; $display("FAIL drop_first_cmd: got %b expected %b", bus.ar_cmd, PRE); end
    step(14);
    n_chk++; if (bus.ar_cmd !== NOP || bus.ar_debt !== 4'd1) begin n_fail++; $display("FAIL drop_trfc2: got cmd %b debt %0d expected 0111 1", bus.ar_cmd, bus.ar_debt); end
    bus.init_end = 1'b0;
    bus.ar_en = 1'b0;
    step(1);
    n_chk++; if (bus.ar_cmd !== NOP || bus.ar_debt !== 4'd0 || bus.ar_req !== 1'b0) begin n_fail++; $display("FAIL drop_next: got cmd %b debt %0d req %b expected 0111 0 0", bus.ar_cmd, bus.ar_debt, bus.ar_req); end
    n_chk++; if (bus.ar_ovf !== 1'b1) begin n_fail++; $display("FAIL drop_ovf: got %b expected 1", bus.ar_ovf); end
    for (int i = 0; i < 10; i++) begin
      if (bus.ar_end !== 1'b0 || bus.ar_cmd !== NOP) saw_bad = 1'b1;
      step(1);
    end
    n_chk++; if (saw_bad) begin n_fail++; $display("FAIL drop_no_end: got end/non-NOP 1 expected 0"); end
`ifdef SDRAM_AREF_STATS_EN
    n_chk++; if (bus.ar_stat_cnt !== 16'd13) begin n_fail++; $display("FAIL drop_stat: got %0d expected 13", bus.ar_stat_cnt); end
`endif
  endtask

  task automatic test_reset_mid_trfc();
    bus.init_end = 1'b1;
    cyc = 0;
    wait_until(200);
    n_chk++; if (bus.ar_debt !== 4'd2 || bus.ar_req !== 1'b1) begin n_fail++; $display("FAIL mrst_pre: got debt %0d req %b expected 2 1", bus.ar_debt, bus.ar_req); end
    bus.ar_en = 1'b1;
    step(1);
    bus.ar_en = 1'b0;
    step(5);
    n_chk++; if (bus.ar_cmd !== NOP || bus.ar_debt !== 4'd1) begin n_fail++; $display("FAIL mrst_trfc: got cmd %b debt %0d expected 0111 1", bus.ar_cmd, bus.ar_debt); end
`ifdef SDRAM_AREF_STATS_EN
    n_chk++; if (bus.ar_stat_cnt !== 16'd14) begin n_fail++; $display("FAIL mrst_stat_pre: got %0d expected 14", bus.ar_stat_cnt); end
`endif
    #2;
    ar_rst_n = 1'b0;
    #1;
    n_chk++; if (bus.ar_cmd !== NOP || bus.ar_addr !== 13'h1FFF || bus.ar_bank !== 2'b11) begin n_fail++; $display("FAIL mrst_cmd: got cmd %b addr %h bank %b expected 0111 1fff 11", bus.ar_cmd, bus.ar_addr, bus.ar_bank); end
    n_chk++; if (bus.ar_debt !== 4'd0 || {bus.ar_req, bus.ar_urgent, bus.ar_end, bus.ar_ovf} !== 4'b0000) begin n_fail++; $display("FAIL mrst_state: got debt %0d flags %b expected 0 0000", bus.ar_debt, {bus.ar_req, bus.ar_urgent, bus.ar_end, bus.ar_ovf}); end
`ifdef SDRAM_AREF_STATS_EN
    n_chk++; if (bus.ar_stat_cnt !== 16'd0) begin n_fail++; $display("FAIL mrst_stat: got %0d expected 0", bus.ar_stat_cnt); end
`endif
    bus.init_end = 1'b0;
    step(2);
    ar_rst_n = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_init_clear();
    test_single();
    test_burst();
    test_urgent();
    test_init_drop();
    test_reset_mid_trfc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
